adc_result_fifo: RTL and testbench

Downstream consumer of the ADC7610 conversion controller. It captures each averaged result word when the controller's `adc_done` rises and checks the `2'b10` tag in bits [15:14]. It tags the 14-bit sample with a rolling sequence number and buffers it in a show-ahead FIFO for the host/bus side, keeping overflow, drop, bad-tag and min/max statistics.

---
 rtl/adc_result_fifo.sv | 123 ++++++++++++
 tb/tb_adc_result_fifo.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/adc_result_fifo.sv
// Result buffer behind the ADC7610 conversion controller. It captures one word per adc_done pulse
// and checks its tag, then queues {seq, sample} in a show-ahead FIFO while tracking drops, bad tags and min/max.
module adc_result_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  adc_done,
    input  logic [15:0]           adc_data,
    input  logic                  clr,
    input  logic                  rd_en,
    output logic [15:0]           rd_data,
    output logic                  rd_valid,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  overflow,
    output logic [7:0]            drop_cnt,
    output logic [7:0]            bad_cnt,
    output logic [13:0]           min_val,
    output logic [13:0]           max_val
);
    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] FULL_LEVEL = PW'(1 << DEPTH_LOG2);

    logic          done_q1, done_q2;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]    seq_q, seq_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic [7:0]    bad_cnt_q, bad_cnt_d;
    logic [13:0]   min_q, min_d;
    logic [13:0]   max_q, max_d;
    logic [15:0]   mem [1 << DEPTH_LOG2];

    logic cap, good, bad, pop, wr_en;

    always_comb begin
        level    = wr_ptr_q - rd_ptr_q;
        full     = (level == FULL_LEVEL);
        rd_valid = (level != '0);
        cap      = done_q1 & ~done_q2;
        good     = cap & (adc_data[15:14] == 2'b10);
        bad      = cap & (adc_data[15:14] != 2'b10);
        // Pop is qualified by the pre-write rd_valid, so a write into an empty FIFO is never popped in the same cycle.
        pop      = rd_en & rd_valid;
        wr_en    = good & (~full | pop);
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        seq_d      = seq_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        min_d      = min_q;
        max_d      = max_q;
        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            seq_d      = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
            bad_cnt_d  = '0;
            min_d      = 14'h3FFF;
            max_d      = 14'h0000;
        end else begin
            if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
            if (good) begin
                if (adc_data[13:0] < min_q) min_d = adc_data[13:0];
                if (adc_data[13:0] > max_q) max_d = adc_data[13:0];
                // seq advances on drops too so the host sees the gap.
                seq_d = seq_q + 1'b1;
                if (wr_en) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end else begin
                    overflow_d = 1'b1;
                    if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 1'b1;
                end
            end
            if (bad && bad_cnt_q != 8'hFF) bad_cnt_d = bad_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q1    <= 1'b0;
            done_q2    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            bad_cnt_q  <= '0;
            min_q      <= 14'h3FFF;
            max_q      <= 14'h0000;
        end else begin
            done_q1    <= adc_done;
            done_q2    <= done_q1;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            min_q      <= min_d;
            max_q      <= max_d;
        end
    end

    // Storage is deliberately unreset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en && !clr) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= {seq_q, adc_data[13:0]};
    end

    assign rd_data  = mem[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
    assign bad_cnt  = bad_cnt_q;
    assign min_val  = min_q;
    assign max_val  = max_q;
endmodule

// File: tb/tb_adc_result_fifo.sv
// Directed bench for adc_result_fifo: capture, hold-high pulse, overflow, bad tag,
// pop-while-full and clear collisions, against hand-computed values.
module tb_adc_result_fifo;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        adc_done = 1'b0;
    logic [15:0] adc_data = 16'h0000;
    logic        clr = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [4:0]  level;
    logic        full;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic [7:0]  bad_cnt;
    logic [13:0] min_val;
    logic [13:0] max_val;

    int checks = 0;
    int failures = 0;

    adc_result_fifo #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .reset(reset), .adc_done(adc_done), .adc_data(adc_data),
        .clr(clr), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .level(level), .full(full), .overflow(overflow), .drop_cnt(drop_cnt),
        .bad_cnt(bad_cnt), .min_val(min_val), .max_val(max_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // adc_done high for two cycles; optional rd_en/clr driven in the cap cycle.
    task automatic pulse(input logic [15:0] d, input logic do_rd, input logic do_clr);
        @(negedge clk);
        adc_done = 1'b1;
        adc_data = d;
        @(negedge clk);
        rd_en = do_rd;
        clr   = do_clr;
        @(negedge clk);
        rd_en    = 1'b0;
        clr      = 1'b0;
        adc_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pop_chk(input string tag, input int exp);
        chk(tag, rd_data, exp);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_level", level, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_bad", bad_cnt, 0);
        chk("rst_min", min_val, 14'h3FFF);
        chk("rst_max", max_val, 0);
        reset = 1'b1;
        @(negedge clk);

        // Pop while empty has no effect
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("empty_pop_level", level, 0);

        // Three pulses, seq 0..2
        pulse(16'h8005, 1'b0, 1'b0);
        pulse(16'h8123, 1'b0, 1'b0);
        pulse(16'hBFFF, 1'b0, 1'b0);
        chk("t1_level", level, 3);
        chk("t1_min", min_val, 14'h0005);
        chk("t1_max", max_val, 14'h3FFF);
        pop_chk("t1_rd0", 16'h0005);
        pop_chk("t1_rd1", 16'h4123);
        pop_chk("t1_rd2", 16'hBFFF);
        chk("t1_empty", rd_valid, 0);

        // Long adc_done: one capture, write at second sampling edge
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        adc_done = 1'b1;
        adc_data = 16'h8ABC;
        @(negedge clk);
        chk("t2_lat_e", level, 0);
        @(negedge clk);
        chk("t2_lat_e1", level, 1);
        chk("t2_valid", rd_valid, 1);
        repeat (8) @(negedge clk);
        adc_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_level", level, 1);
        chk("t2_head", rd_data, 16'h0ABC);

        // Seventeen good pulses, no reads
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 17; i++) pulse(16'h8000 | 16'(i), 1'b0, 1'b0);
        chk("t3_full", full, 1);
        chk("t3_level", level, 16);
        chk("t3_ovf", overflow, 1);
        chk("t3_drop", drop_cnt, 1);
        chk("t3_min", min_val, 0);
        chk("t3_max", max_val, 14'h0010);
        chk("t3_head", rd_data, 16'h0000);

        // Bad tag
        pulse(16'h4001, 1'b0, 1'b0);
        chk("t4_bad", bad_cnt, 1);
        chk("t4_level", level, 16);
        chk("t4_min", min_val, 0);
        chk("t4_max", max_val, 14'h0010);

        // Full, pop coincident with cap
        pulse(16'h8020, 1'b1, 1'b0);
        chk("t5_level", level, 16);
        chk("t5_drop", drop_cnt, 1);
        for (int i = 1; i < 16; i++)
            pop_chk($sformatf("t5_rd%0d", i), ((i % 4) << 14) | i);
        pop_chk("t5_new", 16'h4020);
        chk("t5_empty", level, 0);

        // clr coincident with cap and rd_en
        pulse(16'h8100, 1'b0, 1'b0);
        pulse(16'h8200, 1'b0, 1'b0);
        chk("t6_pre_level", level, 2);
        pulse(16'h8300, 1'b1, 1'b1);
        chk("t6_level", level, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_drop", drop_cnt, 0);
        chk("t6_bad", bad_cnt, 0);
        chk("t6_min", min_val, 14'h3FFF);
        chk("t6_max", max_val, 0);
        pulse(16'h8777, 1'b0, 1'b0);
        chk("t6_next_level", level, 1);
        chk("t6_next_seq0", rd_data, 16'h0777);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
